// File: rtl/lsu_axi_gen.sv
// Load/store unit bridging EXU memory requests to an AXI-Lite master port.
// One transaction in flight; handles lane steering, strobes, load extension and error reporting.
module lsu_axi_gen #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned STRB_W     = AXI_DATA_W / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wen_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_signed_i,
  input  logic [XLEN-1:0]       req_addr_i,
  input  logic [XLEN-1:0]       req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [XLEN-1:0]       rsp_rdata_o,
  output logic [1:0]            rsp_err_o,
  output logic                  mst_ar_valid_o,
  output logic [AXI_ADDR_W-1:0] mst_ar_addr_o,
  input  logic                  mst_ar_ready_i,
  input  logic                  mst_r_valid_i,
  input  logic [AXI_DATA_W-1:0] mst_r_data_i,
  input  logic [1:0]            mst_r_resp_i,
  output logic                  mst_r_ready_o,
  output logic                  mst_aw_valid_o,
  output logic [AXI_ADDR_W-1:0] mst_aw_addr_o,
  input  logic                  mst_aw_ready_i,
  output logic                  mst_w_valid_o,
  output logic [AXI_DATA_W-1:0] mst_w_data_o,
  output logic [STRB_W-1:0]     mst_w_strb_o,
  input  logic                  mst_w_ready_i,
  input  logic                  mst_b_valid_i,
  input  logic [1:0]            mst_b_resp_i,
  output logic                  mst_b_ready_o
);

  localparam int unsigned OFF_W = $clog2(STRB_W);

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_BUS   = 2'd2;
  localparam logic [1:0] ERR_SIZE  = 2'd3;

  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AWW, WR_B, RESP} state_e;

  state_e                state_q, state_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_d;
  logic [AXI_DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic [1:0]            err_q, err_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  req_ready_q, req_ready_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  r_ready_q, r_ready_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  b_ready_q, b_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;

  logic [OFF_W-1:0]      req_off;
  logic [AXI_ADDR_W-1:0] req_addr_aligned;

  // Natural alignment check against the access size.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
    unique case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = a[0];
      2'd2:    misaligned = |a[1:0];
      default: misaligned = |a[2:0];
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] lane_strb(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [15:0] m;
    m = 16'((16'd1 << (16'd1 << size)) - 16'd1);
    lane_strb = STRB_W'(m << off);
  endfunction

  // Pick the addressed bytes out of the beat, then sign- or zero-extend them.
  function automatic logic [XLEN-1:0] load_ext(input logic [AXI_DATA_W-1:0] data,
                                               input logic [OFF_W-1:0] off,
                                               input logic [1:0] size,
                                               input logic sgn);
    logic [AXI_DATA_W-1:0] sh;
    logic [XLEN-1:0]       mask;
    logic                  msb;
    sh = data >> {off, 3'b000};
    unique case (size)
      2'd0:    begin mask = XLEN'(64'h0000_0000_0000_00FF); msb = sh[7];  end
      2'd1:    begin mask = XLEN'(64'h0000_0000_0000_FFFF); msb = sh[15]; end
      2'd2:    begin mask = XLEN'(64'h0000_0000_FFFF_FFFF); msb = sh[31]; end
      default: begin mask = '1;                             msb = 1'b0;   end
    endcase
    load_ext = (XLEN'(sh) & mask) | ({XLEN{sgn & msb}} & ~mask);
  endfunction

  always_comb begin
    req_addr_aligned = AXI_ADDR_W'(req_addr_i);
    req_addr_aligned[OFF_W-1:0] = '0;
  end

  assign req_off = req_addr_i[OFF_W-1:0];

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    size_d    = size_q;
    sgn_d     = sgn_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          off_d     = req_off;
          size_d    = req_size_i;
          sgn_d     = req_signed_i;
          addr_d    = req_addr_aligned;
          wdata_d   = AXI_DATA_W'(req_wdata_i) << {req_off, 3'b000};
          strb_d    = lane_strb(req_size_i, req_off);
          rdata_d   = '0;
          err_d     = ERR_OK;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if ((req_size_i == 2'd3) && (XLEN == 32)) begin
            err_d   = ERR_SIZE;
            state_d = RESP;
          end else if (misaligned(req_size_i, req_addr_i[2:0])) begin
            err_d   = ERR_ALIGN;
            state_d = RESP;
          end else if (req_wen_i) begin
            state_d = WR_AWW;
          end else begin
            state_d = RD_AR;
          end
        end
      end
      RD_AR: begin
        if (mst_ar_ready_i) state_d = RD_R;
      end
      RD_R: begin
        if (mst_r_valid_i) begin
          if (mst_r_resp_i != 2'd0) begin
            err_d   = ERR_BUS;
            rdata_d = '0;
          end else begin
            rdata_d = load_ext(mst_r_data_i, off_q, size_q, sgn_q);
          end
          state_d = RESP;
        end
      end
      WR_AWW: begin
        aw_done_d = aw_done_q | (aw_valid_q & mst_aw_ready_i);
        w_done_d  = w_done_q | (w_valid_q & mst_w_ready_i);
        if (aw_done_d && w_done_d) state_d = WR_B;
      end
      WR_B: begin
        if (mst_b_valid_i) begin
          err_d   = (mst_b_resp_i != 2'd0) ? ERR_BUS : ERR_OK;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Handshake outputs are registered copies of the next-state decode.
    req_ready_d = (state_d == IDLE);
    ar_valid_d  = (state_d == RD_AR);
    r_ready_d   = (state_d == RD_R);
    aw_valid_d  = (state_d == WR_AWW) && !aw_done_d;
    w_valid_d   = (state_d == WR_AWW) && !w_done_d;
    b_ready_d   = (state_d == WR_B);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      off_q       <= '0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_ready_q <= 1'b1;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      req_ready_q <= req_ready_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      aw_valid_q  <= aw_valid_d;
      w_valid_q   <= w_valid_d;
      b_ready_q   <= b_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign mst_ar_valid_o = ar_valid_q;
  assign mst_ar_addr_o  = addr_q;
  assign mst_r_ready_o  = r_ready_q;
  assign mst_aw_valid_o = aw_valid_q;
  assign mst_aw_addr_o  = addr_q;
  assign mst_w_valid_o  = w_valid_q;
  assign mst_w_data_o   = wdata_q;
  assign mst_w_strb_o   = strb_q;
  assign mst_b_ready_o  = b_ready_q;

endmodule

// File: tb/tb_lsu_axi_gen.sv
// Directed bench for lsu_axi_gen: a 32-bit and a 64-bit instance driven by hand-written AXI responses.
module tb_lsu_axi_gen;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // 32-bit instance
  logic        req_valid, req_ready, req_wen, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] ar_addr, r_data;
  logic [1:0]  r_resp;
  logic        aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [31:0] aw_addr, w_data;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp;

  lsu_axi_gen #(.XLEN(32), .AXI_ADDR_W(32), .AXI_DATA_W(32)) dut32 (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_wen_i(req_wen),
    .req_size_i(req_size), .req_signed_i(req_signed), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mst_ar_valid_o(ar_valid), .mst_ar_addr_o(ar_addr), .mst_ar_ready_i(ar_ready),
    .mst_r_valid_i(r_valid), .mst_r_data_i(r_data), .mst_r_resp_i(r_resp), .mst_r_ready_o(r_ready),
    .mst_aw_valid_o(aw_valid), .mst_aw_addr_o(aw_addr), .mst_aw_ready_i(aw_ready),
    .mst_w_valid_o(w_valid), .mst_w_data_o(w_data), .mst_w_strb_o(w_strb), .mst_w_ready_i(w_ready),
    .mst_b_valid_i(b_valid), .mst_b_resp_i(b_resp), .mst_b_ready_o(b_ready)
  );

  // 64-bit instance
  logic        x_req_valid, x_req_ready, x_req_wen, x_req_signed;
  logic [1:0]  x_req_size;
  logic [63:0] x_req_addr, x_req_wdata;
  logic        x_rsp_valid, x_rsp_ready;
  logic [63:0] x_rsp_rdata;
  logic [1:0]  x_rsp_err;
  logic        x_ar_valid, x_ar_ready, x_r_valid, x_r_ready;
  logic [31:0] x_ar_addr;
  logic [63:0] x_r_data;
  logic [1:0]  x_r_resp;
  logic        x_aw_valid, x_aw_ready, x_w_valid, x_w_ready, x_b_valid, x_b_ready;
  logic [31:0] x_aw_addr;
  logic [63:0] x_w_data;
  logic [7:0]  x_w_strb;
  logic [1:0]  x_b_resp;

  lsu_axi_gen #(.XLEN(64), .AXI_ADDR_W(32), .AXI_DATA_W(64)) dut64 (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(x_req_valid), .req_ready_o(x_req_ready), .req_wen_i(x_req_wen),
    .req_size_i(x_req_size), .req_signed_i(x_req_signed), .req_addr_i(x_req_addr),
    .req_wdata_i(x_req_wdata), .rsp_valid_o(x_rsp_valid), .rsp_ready_i(x_rsp_ready),
    .rsp_rdata_o(x_rsp_rdata), .rsp_err_o(x_rsp_err),
    .mst_ar_valid_o(x_ar_valid), .mst_ar_addr_o(x_ar_addr), .mst_ar_ready_i(x_ar_ready),
    .mst_r_valid_i(x_r_valid), .mst_r_data_i(x_r_data), .mst_r_resp_i(x_r_resp), .mst_r_ready_o(x_r_ready),
    .mst_aw_valid_o(x_aw_valid), .mst_aw_addr_o(x_aw_addr), .mst_aw_ready_i(x_aw_ready),
    .mst_w_valid_o(x_w_valid), .mst_w_data_o(x_w_data), .mst_w_strb_o(x_w_strb), .mst_w_ready_i(x_w_ready),
    .mst_b_valid_i(x_b_valid), .mst_b_resp_i(x_b_resp), .mst_b_ready_o(x_b_ready)
  );

  task automatic req32(input logic wen, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_wen = wen; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    step();
    req_valid = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic rsp_release32();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  // Zero-wait load on the 32-bit instance, checking address, latency and result.
  task automatic load32(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] rdat,
                        input logic [31:0] exp_ar, input logic [31:0] exp_rd);
    req32(1'b0, size, sgn, addr, 32'h0);
    check({tag, ".ar_valid"}, ar_valid, 1);
    check({tag, ".ar_addr"}, ar_addr, exp_ar);
    check({tag, ".req_ready"}, req_ready, 0);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    check({tag, ".r_ready"}, r_ready, 1);
    check({tag, ".ar_drop"}, ar_valid, 0);
    r_valid = 1'b1; r_data = rdat; r_resp = 2'b00;
    step();
    r_valid = 1'b0; r_data = '0;
    check({tag, ".rsp_valid"}, rsp_valid, 1);
    check({tag, ".rdata"}, rsp_rdata, exp_rd);
    check({tag, ".err"}, rsp_err, 0);
    rsp_release32();
    check({tag, ".idle"}, req_ready, 1);
  endtask

  initial begin
    {req_valid, req_wen, req_signed, rsp_ready, ar_ready, r_valid, aw_ready, w_ready, b_valid} = '0;
    req_size = '0; req_addr = '0; req_wdata = '0; r_data = '0; r_resp = '0; b_resp = '0;
    {x_req_valid, x_req_wen, x_req_signed, x_rsp_ready, x_ar_ready, x_r_valid,
     x_aw_ready, x_w_ready, x_b_valid} = '0;
    x_req_size = '0; x_req_addr = '0; x_req_wdata = '0; x_r_data = '0; x_r_resp = '0; x_b_resp = '0;

    #12;
    check("rst.req_ready", req_ready, 1);
    check("rst.ar_valid", ar_valid, 0);
    check("rst.aw_w_valid", {aw_valid, w_valid}, 0);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.rdata_err", {rsp_rdata, rsp_err}, 0);
    check("rst64.req_ready", x_req_ready, 1);
    @(negedge clk_i) rst_i = 1'b1;
    step();

    // Stray R/B beats while idle are not accepted
    r_valid = 1'b1; b_valid = 1'b1;
    check("idle.r_ready", r_ready, 0);
    check("idle.b_ready", b_ready, 0);
    step();
    r_valid = 1'b0; b_valid = 1'b0;
    check("idle.no_rsp", rsp_valid, 0);

    load32("lw",  32'h8000_0004, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h8000_0004, 32'hDEAD_BEEF);
    load32("lbs", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_FF7F, 32'h8000_0000, 32'hFFFF_FF80);
    load32("lbu", 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_FF7F, 32'h8000_0000, 32'h0000_0080);
    load32("lhs", 32'h0000_0102, 2'd1, 1'b1, 32'h8001_0000, 32'h0000_0100, 32'hFFFF_8001);

    // SH with AW ready two cycles ahead of W ready
    req32(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_1234);
    check("sh.valids", {aw_valid, w_valid}, 2'b11);
    check("sh.aw_addr", aw_addr, 32'h8000_0000);
    check("sh.w_hi", w_data[31:16], 16'h1234);
    check("sh.strb", w_strb, 4'b1100);
    aw_ready = 1'b1;
    step();
    aw_ready = 1'b0;
    check("sh.aw_drop", {aw_valid, w_valid}, 2'b01);
    step();
    check("sh.w_hold", {aw_valid, w_valid, b_ready}, 3'b010);
    w_ready = 1'b1;
    step();
    w_ready = 1'b0;
    check("sh.b_ready", {w_valid, b_ready}, 2'b01);
    b_valid = 1'b1; b_resp = 2'b00;
    step();
    b_valid = 1'b0;
    check("sh.rsp", {rsp_valid, rsp_err}, {1'b1, 2'd0});
    check("sh.rdata", rsp_rdata, 0);
    rsp_release32();

    // SB with simultaneous AW/W handshake and a bus error response, held by WBU back-pressure
    req32(1'b1, 2'd0, 1'b0, 32'h1000_0001, 32'h0000_00AB);
    check("sb.strb", w_strb, 4'b0010);
    check("sb.w_byte", w_data[15:8], 8'hAB);
    aw_ready = 1'b1; w_ready = 1'b1;
    step();
    aw_ready = 1'b0; w_ready = 1'b0;
    check("sb.both_drop", {aw_valid, w_valid, b_ready}, 3'b001);
    b_valid = 1'b1; b_resp = 2'b11;
    step();
    b_valid = 1'b0; b_resp = 2'b00;
    check("sb.err", {rsp_valid, rsp_err}, {1'b1, 2'd2});
    step();
    check("sb.hold", {rsp_valid, rsp_err, req_ready}, {1'b1, 2'd2, 1'b0});
    rsp_release32();

    // Pre-check errors: misaligned LW, SD on a 32-bit unit
    req32(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'h0);
    check("mis.rsp", {rsp_valid, rsp_err}, {1'b1, 2'd1});
    check("mis.no_ar", ar_valid, 0);
    rsp_release32();
    req32(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF);
    check("sd32.rsp", {rsp_valid, rsp_err}, {1'b1, 2'd3});
    check("sd32.no_aw", {aw_valid, w_valid}, 0);
    rsp_release32();

    // 64-bit: LD with SLVERR, then back-to-back SW to 0xC
    x_req_valid = 1'b1; x_req_wen = 1'b0; x_req_size = 2'd3; x_req_addr = 64'h8;
    step();
    x_req_valid = 1'b0;
    check("ld64.ar", {x_ar_valid, x_ar_addr}, {1'b1, 32'h8});
    x_ar_ready = 1'b1;
    step();
    x_ar_ready = 1'b0;
    x_r_valid = 1'b1; x_r_resp = 2'b10; x_r_data = 64'h1122_3344_5566_7788;
    step();
    x_r_valid = 1'b0; x_r_resp = 2'b00;
    check("ld64.err", {x_rsp_valid, x_rsp_err}, {1'b1, 2'd2});
    check("ld64.rdata", x_rsp_rdata, 64'h0);
    x_rsp_ready = 1'b1;
    step();
    x_rsp_ready = 1'b0;
    check("sw64.ready", x_req_ready, 1);
    x_req_valid = 1'b1; x_req_wen = 1'b1; x_req_size = 2'd2; x_req_addr = 64'hC;
    x_req_wdata = 64'h0000_0000_1122_3344;
    step();
    x_req_valid = 1'b0;
    check("sw64.aw_addr", x_aw_addr, 32'h8);
    check("sw64.strb", x_w_strb, 8'hF0);
    check("sw64.w_hi", x_w_data[63:32], 32'h1122_3344);
    x_aw_ready = 1'b1; x_w_ready = 1'b1;
    step();
    x_aw_ready = 1'b0; x_w_ready = 1'b0;
    x_b_valid = 1'b1;
    step();
    x_b_valid = 1'b0;
    check("sw64.rsp", {x_rsp_valid, x_rsp_err}, {1'b1, 2'd0});
    x_rsp_ready = 1'b1;
    step();
    x_rsp_ready = 1'b0;

    // 64-bit signed LW from the upper lane
    x_req_valid = 1'b1; x_req_wen = 1'b0; x_req_size = 2'd2; x_req_signed = 1'b1; x_req_addr = 64'hC;
    step();
    x_req_valid = 1'b0;
    x_ar_ready = 1'b1;
    step();
    x_ar_ready = 1'b0;
    x_r_valid = 1'b1; x_r_data = 64'h89AB_CDEF_0000_0000;
    step();
    x_r_valid = 1'b0;
    check("lw64s.rdata", x_rsp_rdata, 64'hFFFF_FFFF_89AB_CDEF);
    x_rsp_ready = 1'b1;
    step();
    x_rsp_ready = 1'b0;

    // Asynchronous reset while waiting in RD_R
    req32(1'b0, 2'd2, 1'b0, 32'h8000_0000, 32'h0);
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    check("rstmid.r_ready_pre", r_ready, 1);
    #2 rst_i = 1'b0;
    #1;
    check("rstmid.drop", {ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_valid}, 0);
    check("rstmid.req_ready", req_ready, 1);
    @(negedge clk_i) rst_i = 1'b1;
    step();
    check("rstmid.after", {req_ready, rsp_valid}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
